// File: rtl/axi4_burst_master_if.sv
// ---------------------------------------------------------------------------
// axi4_burst_master_if
//   AXI4 signal bundle between the burst master and the NoC wrapper / slave.
//   Only the fields the burst master uses are carried.
//
//   Parameters : ID_WIDTH, ADDR_WIDTH, DATA_WIDTH
//   Modports   : master - drives AW/W/AR payload+valid, B/R ready
//                slave  - drives AW/W/AR ready, B/R payload+valid
// ---------------------------------------------------------------------------
interface axi4_burst_master_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  // Write address channel
  logic                    axi_awvalid;
  logic                    axi_awready;
  logic [ID_WIDTH-1:0]     axi_awid;
  logic [ADDR_WIDTH-1:0]   axi_awaddr;
  logic [7:0]              axi_awlen;
  logic [2:0]              axi_awsize;
  logic [1:0]              axi_awburst;
  // Write data channel
  logic                    axi_wvalid;
  logic                    axi_wready;
  logic [DATA_WIDTH-1:0]   axi_wdata;
  logic [DATA_WIDTH/8-1:0] axi_wstrb;
  logic                    axi_wlast;
  // Write response channel
  logic                    axi_bvalid;
  logic                    axi_bready;
  logic [ID_WIDTH-1:0]     axi_bid;
  logic [1:0]              axi_bresp;
  // Read address channel
  logic                    axi_arvalid;
  logic                    axi_arready;
  logic [ID_WIDTH-1:0]     axi_arid;
  logic [ADDR_WIDTH-1:0]   axi_araddr;
  logic [7:0]              axi_arlen;
  logic [2:0]              axi_arsize;
  logic [1:0]              axi_arburst;
  // Read data channel
  logic                    axi_rvalid;
  logic                    axi_rready;
  logic [ID_WIDTH-1:0]     axi_rid;
  logic [DATA_WIDTH-1:0]   axi_rdata;
  logic [1:0]              axi_rresp;
  logic                    axi_rlast;

  modport master (
    output axi_awvalid, axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
    input  axi_awready,
    output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
    input  axi_wready,
    input  axi_bvalid, axi_bid, axi_bresp,
    output axi_bready,
    output axi_arvalid, axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
    input  axi_arready,
    input  axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast,
    output axi_rready
  );

  modport slave (
    input  axi_awvalid, axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
    output axi_awready,
    input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
    output axi_wready,
    output axi_bvalid, axi_bid, axi_bresp,
    input  axi_bready,
    input  axi_arvalid, axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
    output axi_arready,
    output axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast,
    input  axi_rready
  );
endinterface

// File: rtl/axi4_burst_master.sv
// ---------------------------------------------------------------------------
// axi4_burst_master
//   AXI4 traffic generator endpoint. A start_write pulse issues one INCR
//   write burst of BURST_LEN beats carrying DATA_BASE, DATA_BASE+1, ...;
//   a start_read pulse issues one INCR read burst whose beats are captured
//   into the word array rdata at (addr + beat) mod MEM_DEPTH. The write and
//   read engines are independent and may run concurrently.
//
//   Ports:
//     CLK          clock, rising edge
//     RST          synchronous active-high reset
//     start_write  one-cycle pulse, launch a write burst (ignored if busy)
//     start_read   one-cycle pulse, launch a read burst (ignored if busy)
//     addr         word-index start address, sampled with the start pulse
//     write_done   one-cycle pulse after the B handshake
//     read_done    one-cycle pulse after the rlast handshake
//     axi          AXI4 master modport
// ---------------------------------------------------------------------------
module axi4_burst_master #(
  parameter int                    ID         = 0,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    BURST_LEN  = 8,
  parameter logic [DATA_WIDTH-1:0] DATA_BASE  = DATA_WIDTH'(64'hdeadbeefdeadbeef),
  parameter int                    MEM_DEPTH  = 16   // power of two: index wraps by truncation
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start_write,
  input  logic                  start_read,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  write_done,
  output logic                  read_done,
  axi4_burst_master_if.master   axi
);

  localparam int                BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int                IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [2:0]        AXSIZE    = 3'($clog2(DATA_WIDTH / 8));

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  logic [1:0]            w_state;
  logic [BEAT_W-1:0]     w_beat;
  logic [1:0]            r_state;
  logic [IDX_W-1:0]      r_ptr;     // capture slot for the next read beat
  logic [DATA_WIDTH-1:0] rdata [MEM_DEPTH];

  // Fixed burst attributes
  assign axi.axi_awid    = ID_WIDTH'(ID);
  assign axi.axi_awlen   = 8'(BURST_LEN - 1);
  assign axi.axi_awsize  = AXSIZE;
  assign axi.axi_awburst = 2'b01;
  assign axi.axi_wstrb   = '1;
  assign axi.axi_arid    = ID_WIDTH'(ID);
  assign axi.axi_arlen   = 8'(BURST_LEN - 1);
  assign axi.axi_arsize  = AXSIZE;
  assign axi.axi_arburst = 2'b01;

  // Response IDs and status codes are accepted but not interpreted.
  logic unused_inputs;
  assign unused_inputs = ^{axi.axi_bid, axi.axi_bresp, axi.axi_rid, axi.axi_rresp};

  // ---------------- write engine ----------------
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_state         <= W_IDLE;
      w_beat          <= '0;
      write_done      <= 1'b0;
      axi.axi_awvalid <= 1'b0;
      axi.axi_awaddr  <= '0;
      axi.axi_wvalid  <= 1'b0;
      axi.axi_wdata   <= '0;
      axi.axi_wlast   <= 1'b0;
      axi.axi_bready  <= 1'b0;
    end else begin
      write_done <= 1'b0;
      case (w_state)
        W_IDLE: if (start_write) begin
          axi.axi_awaddr  <= addr;
          axi.axi_awvalid <= 1'b1;
          w_state         <= W_ADDR;
        end
        W_ADDR: if (axi.axi_awready) begin
          axi.axi_awvalid <= 1'b0;
          axi.axi_wvalid  <= 1'b1;
          axi.axi_wdata   <= DATA_BASE;
          axi.axi_wlast   <= (LAST_BEAT == '0);
          w_beat          <= '0;
          w_state         <= W_DATA;
        end
        W_DATA: if (axi.axi_wready) begin
          if (w_beat == LAST_BEAT) begin
            axi.axi_wvalid <= 1'b0;
            axi.axi_wlast  <= 1'b0;
            axi.axi_bready <= 1'b1;
            w_state        <= W_RESP;
          end else begin
            // Next beat's payload is prepared here so wdata/wlast stay registered.
            w_beat        <= w_beat + BEAT_W'(1);
            axi.axi_wdata <= axi.axi_wdata + DATA_WIDTH'(1);
            axi.axi_wlast <= ((w_beat + BEAT_W'(1)) == LAST_BEAT);
          end
        end
        default: if (axi.axi_bvalid) begin   // W_RESP
          axi.axi_bready <= 1'b0;
          write_done     <= 1'b1;
          w_state        <= W_IDLE;
        end
      endcase
    end
  end

  // ---------------- read engine ----------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state         <= R_IDLE;
      r_ptr           <= '0;
      read_done       <= 1'b0;
      axi.axi_arvalid <= 1'b0;
      axi.axi_araddr  <= '0;
      axi.axi_rready  <= 1'b0;
      // NOTE: the capture array is cleared by reset because the bench inspects
      // it directly; an array without this requirement would be left unreset.
      for (int i = 0; i < MEM_DEPTH; i++) rdata[i] <= '0;
    end else begin
      read_done <= 1'b0;
      case (r_state)
        R_IDLE: if (start_read) begin
          axi.axi_araddr  <= addr;
          r_ptr           <= addr[IDX_W-1:0];
          axi.axi_arvalid <= 1'b1;
          r_state         <= R_ADDR;
        end
        R_ADDR: if (axi.axi_arready) begin
          axi.axi_arvalid <= 1'b0;
          axi.axi_rready  <= 1'b1;
          r_state         <= R_DATA;
        end
        R_DATA: if (axi.axi_rvalid) begin
          rdata[r_ptr] <= axi.axi_rdata;
          r_ptr        <= r_ptr + IDX_W'(1);
          // Burst length is trusted to the slave: only rlast terminates.
          if (axi.axi_rlast) begin
            axi.axi_rready <= 1'b0;
            read_done      <= 1'b1;
            r_state        <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_burst_master.sv
module tb_axi4_burst_master;
  localparam int          ID_WIDTH   = 4;
  localparam int          ADDR_WIDTH = 32;
  localparam int          DATA_WIDTH = 64;
  localparam int          BURST_LEN  = 8;
  localparam int          MEM_DEPTH  = 16;
  localparam logic [63:0] DATA_BASE  = 64'hdeadbeefdeadbeef;

  logic                  CLK         = 1'b0;
  logic                  RST         = 1'b1;
  logic                  start_write = 1'b0;
  logic                  start_read  = 1'b0;
  logic [ADDR_WIDTH-1:0] addr        = '0;
  logic                  write_done;
  logic                  read_done;

  axi4_burst_master_if #(.ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) axi ();

  axi4_burst_master #(
    .ID(0), .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .BURST_LEN(BURST_LEN), .DATA_BASE(DATA_BASE), .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST), .start_write(start_write), .start_read(start_read),
    .addr(addr), .write_done(write_done), .read_done(read_done), .axi(axi)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model / recorder state ----------------
  bit          stall = 1'b0;
  int          aw_count, w_count, ar_count, wd_count, rd_count;
  int          aw_cyc, ar_cyc, w_first_cyc, w_last_cyc, wd_cyc, rd_cyc;
  logic [31:0] aw_addr_seen, ar_addr_seen;
  logic [7:0]  aw_len_seen, ar_len_seen, w_strb_seen;
  logic [2:0]  aw_size_seen, ar_size_seen;
  logic [1:0]  aw_burst_seen, ar_burst_seen;
  logic [3:0]  aw_id_seen, ar_id_seen;
  logic [63:0] w_data_q [$];
  bit          w_last_q [$];
  logic [63:0] rd_pat [BURST_LEN];
  logic [63:0] exp_mem [MEM_DEPTH];
  bit          aw_hold, w_hold, ar_hold, w_hold_last;
  logic [31:0] aw_hold_addr, ar_hold_addr;
  logic [63:0] w_hold_data;
  bit          b_pending, b_fire, r_active, r_start, r_fire;
  int          r_beat;

  function automatic bit rnd_ready();
    return stall ? ($urandom_range(0, 1) == 1) : 1'b1;
  endfunction

  // Slave runs on the falling edge: it sets its outputs for the next rising
  // edge and records the handshakes that edge will complete.
  always @(negedge CLK) begin
    if (RST) begin
      axi.axi_awready = 1'b0; axi.axi_wready = 1'b0; axi.axi_arready = 1'b0;
      axi.axi_bvalid  = 1'b0; axi.axi_bid    = '0;   axi.axi_bresp   = '0;
      axi.axi_rvalid  = 1'b0; axi.axi_rlast  = 1'b0; axi.axi_rdata   = '0;
      axi.axi_rid     = '0;   axi.axi_rresp  = '0;
      aw_hold = 0; w_hold = 0; ar_hold = 0;
      b_pending = 0; b_fire = 0; r_active = 0; r_start = 0; r_fire = 0; r_beat = 0;
    end else begin
      if (aw_hold) check("aw_stable", {axi.axi_awvalid, axi.axi_awaddr}, {1'b1, aw_hold_addr});
      if (ar_hold) check("ar_stable", {axi.axi_arvalid, axi.axi_araddr}, {1'b1, ar_hold_addr});
      if (w_hold) begin
        check("w_stable_ctl", {axi.axi_wvalid, axi.axi_wlast}, {1'b1, w_hold_last});
        check("w_stable_data", axi.axi_wdata, w_hold_data);
      end
      if (write_done) begin wd_count++; wd_cyc = cyc; end
      if (read_done)  begin rd_count++; rd_cyc = cyc; end

      // B channel
      if (b_fire) begin axi.axi_bvalid = 1'b0; b_fire = 0; end
      if (b_pending && !axi.axi_bvalid && rnd_ready()) begin
        axi.axi_bvalid = 1'b1; b_pending = 0;
      end
      b_fire = axi.axi_bvalid && axi.axi_bready;

      // W channel
      axi.axi_wready = rnd_ready();
      if (axi.axi_wvalid && axi.axi_wready) begin
        if (w_count == 0) w_first_cyc = cyc;
        w_last_cyc = cyc;
        w_count++;
        w_data_q.push_back(axi.axi_wdata);
        w_last_q.push_back(axi.axi_wlast);
        w_strb_seen &= axi.axi_wstrb;
        if (axi.axi_wlast) b_pending = 1;
      end
      w_hold      = axi.axi_wvalid && !axi.axi_wready;
      w_hold_data = axi.axi_wdata;
      w_hold_last = axi.axi_wlast;

      // AW channel
      axi.axi_awready = rnd_ready();
      if (axi.axi_awvalid && axi.axi_awready) begin
        aw_count++; aw_cyc = cyc;
        aw_addr_seen = axi.axi_awaddr; aw_len_seen = axi.axi_awlen;
        aw_size_seen = axi.axi_awsize; aw_burst_seen = axi.axi_awburst; aw_id_seen = axi.axi_awid;
      end
      aw_hold      = axi.axi_awvalid && !axi.axi_awready;
      aw_hold_addr = axi.axi_awaddr;

      // R channel
      if (r_fire) begin
        axi.axi_rvalid = 1'b0;
        if (axi.axi_rlast) r_active = 0; else r_beat++;
        r_fire = 0;
      end
      if (r_start) begin r_active = 1; r_beat = 0; r_start = 0; end
      if (r_active && !axi.axi_rvalid && rnd_ready()) begin
        axi.axi_rvalid = 1'b1;
        axi.axi_rdata  = rd_pat[r_beat];
        axi.axi_rlast  = (r_beat == BURST_LEN - 1);
      end
      r_fire = axi.axi_rvalid && axi.axi_rready;

      // AR channel
      axi.axi_arready = rnd_ready();
      if (axi.axi_arvalid && axi.axi_arready) begin
        ar_count++; ar_cyc = cyc; r_start = 1;
        ar_addr_seen = axi.axi_araddr; ar_len_seen = axi.axi_arlen;
        ar_size_seen = axi.axi_arsize; ar_burst_seen = axi.axi_arburst; ar_id_seen = axi.axi_arid;
      end
      ar_hold      = axi.axi_arvalid && !axi.axi_arready;
      ar_hold_addr = axi.axi_araddr;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_rec();
    aw_count = 0; w_count = 0; ar_count = 0; wd_count = 0; rd_count = 0;
    w_data_q.delete(); w_last_q.delete(); w_strb_seen = '1;
  endtask

  task automatic pulse(input bit wr, input bit rd, input logic [31:0] a, output int c0);
    @(posedge CLK); #1;
    addr = a; start_write = wr; start_read = rd; c0 = cyc;
    @(posedge CLK); #1;
    start_write = 1'b0; start_read = 1'b0;
  endtask

  task automatic wait_done(input bit is_write, input int bound);
    int n = 0;
    while (((is_write ? wd_count : rd_count) == 0) && n < bound) begin
      @(negedge CLK); n++;
    end
    repeat (5) @(negedge CLK);
  endtask

  task automatic random_pattern();
    for (int i = 0; i < BURST_LEN; i++) rd_pat[i] = {$urandom, $urandom};
  endtask

  // Reference: beat i of a read from word a lands at (a+i) mod MEM_DEPTH.
  task automatic model_read(input logic [31:0] a);
    for (int i = 0; i < BURST_LEN; i++) exp_mem[(int'(a) + i) % MEM_DEPTH] = rd_pat[i];
  endtask

  task automatic compare_mem(input string tag);
    for (int j = 0; j < MEM_DEPTH; j++)
      check($sformatf("%s_mem%0d", tag, j), dut.rdata[j], exp_mem[j]);
  endtask

  task automatic check_write(input string tag, input logic [31:0] a);
    check({tag, "_aw_count"}, aw_count, 1);
    check({tag, "_awaddr"}, aw_addr_seen, a);
    check({tag, "_aw_fields"}, {aw_len_seen, 1'b0, aw_size_seen, 2'b0, aw_burst_seen, aw_id_seen},
          {8'd7, 1'b0, 3'd3, 2'b0, 2'b01, 4'd0});
    check({tag, "_w_count"}, w_count, BURST_LEN);
    for (int i = 0; i < w_data_q.size() && i < BURST_LEN; i++) begin
      check($sformatf("%s_wdata%0d", tag, i), w_data_q[i], DATA_BASE + 64'(i));
      check($sformatf("%s_wlast%0d", tag, i), 64'(w_last_q[i]), 64'(i == BURST_LEN - 1));
    end
    check({tag, "_wstrb"}, w_strb_seen, 8'hff);
    check({tag, "_write_done"}, wd_count, 1);
  endtask

  task automatic check_read(input string tag, input logic [31:0] a);
    check({tag, "_ar_count"}, ar_count, 1);
    check({tag, "_araddr"}, ar_addr_seen, a);
    check({tag, "_ar_fields"}, {ar_len_seen, 1'b0, ar_size_seen, 2'b0, ar_burst_seen, ar_id_seen},
          {8'd7, 1'b0, 3'd3, 2'b0, 2'b01, 4'd0});
    check({tag, "_read_done"}, rd_count, 1);
    compare_mem(tag);
  endtask

  task automatic check_idle_outputs(input string tag);
    check(tag, {axi.axi_awvalid, axi.axi_wvalid, axi.axi_bready, axi.axi_arvalid,
                axi.axi_rready, write_done, read_done}, 7'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c0, c1, n;
    logic [31:0] a;

    for (int j = 0; j < MEM_DEPTH; j++) exp_mem[j] = '0;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check_idle_outputs("reset_outputs");
    compare_mem("reset");

    // Write at word 2, slave always ready, with cycle timing
    stall = 0; clear_rec();
    pulse(1, 0, 32'd2, c0);
    wait_done(1, 200);
    check_write("wr2", 32'd2);
    check("wr2_aw_cycle", aw_cyc, c0 + 1);
    check("wr2_w_first_cycle", w_first_cyc, c0 + 2);
    check("wr2_w_last_cycle", w_last_cyc, c0 + 9);
    check("wr2_done_cycle", wd_cyc, c0 + 11);

    // Read at word 3 returning DATA_BASE+i
    for (int i = 0; i < BURST_LEN; i++) rd_pat[i] = DATA_BASE + 64'(i);
    clear_rec();
    pulse(0, 1, 32'd3, c0);
    wait_done(0, 200);
    model_read(32'd3);
    check_read("rd3", 32'd3);
    check("rd3_ar_cycle", ar_cyc, c0 + 1);
    check("rd3_done_cycle", rd_cyc, c0 + 10);

    // Random stalls on every slave-controlled signal
    stall = 1;
    for (int k = 0; k < 4; k++) begin
      a = $urandom_range(0, 40);
      clear_rec();
      pulse(1, 0, a, c0);
      wait_done(1, 400);
      check_write($sformatf("rnd_wr%0d", k), a);
      a = $urandom_range(0, 40);
      random_pattern();
      clear_rec();
      pulse(0, 1, a, c0);
      wait_done(0, 400);
      model_read(a);
      check_read($sformatf("rnd_rd%0d", k), a);
    end

    // Simultaneous start at word 5, plus a start_write while the write is busy
    random_pattern();
    clear_rec();
    pulse(1, 1, 32'd5, c0);
    pulse(1, 0, 32'd9, c1);
    wait_done(1, 400);
    wait_done(0, 400);
    repeat (20) @(negedge CLK);
    model_read(32'd5);
    check_write("both5", 32'd5);
    check_read("both5", 32'd5);

    // Read at word 12: capture wraps to the start of the array
    stall = 0;
    random_pattern();
    clear_rec();
    pulse(0, 1, 32'd12, c0);
    wait_done(0, 200);
    model_read(32'd12);
    check_read("wrap12", 32'd12);

    // Reset while the write engine is on beat 4
    clear_rec();
    pulse(1, 0, 32'd7, c0);
    n = 0;
    while (w_count < 4 && n < 100) begin @(negedge CLK); n++; end
    check("rst_reached_beat4", w_count, 4);
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    check_idle_outputs("rst_mid_outputs");
    for (int j = 0; j < MEM_DEPTH; j++) exp_mem[j] = '0;
    compare_mem("rst_mid");
    check("rst_mid_no_done", wd_count, 0);

    // Fresh burst after the abandoned one
    clear_rec();
    pulse(1, 0, 32'd7, c0);
    wait_done(1, 200);
    check_write("post_rst", 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop so a wedged run still ends with a verdict.
  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
